clint_timer: RTL

- Memory-mapped machine-timer and software-interrupt responder on the system bus, i.e. the slave end of the req/ready bus driven by each core tile's bus master port.
- Holds a free-running 64-bit mtime, one 64-bit mtimecmp per hart, and one msip bit per hart.
- Drives the per-hart timer_irq and soft_irq lines back into the core tiles.
- The fabric decodes the base address and routes req/ready; this block decodes only bus_addr[7:0].

---
 rtl/clint_pkg.sv | 43 ++++
 rtl/clint_prescaler.sv | 28 ++
 rtl/clint_timer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT timer block: register offsets, handshake
// states and small decode/merge helpers used by the top.
package clint_pkg;

  localparam logic [7:0] CLINT_MTIME_LO      = 8'h00;
  localparam logic [7:0] CLINT_MTIME_HI      = 8'h04;
  localparam logic [7:0] CLINT_MSIP          = 8'h08;
  localparam logic [7:0] CLINT_MTIMECMP_BASE = 8'h10;
  localparam logic [7:0] CLINT_HART_STRIDE   = 8'h08;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_GAP  = 2'd2
  } clint_state_e;

  function automatic logic is_cmp_off(input logic [7:0] off);
    return off >= CLINT_MTIMECMP_BASE;
  endfunction

  // Hart index of an mtimecmp offset; may exceed the number of harts served.
  function automatic logic [7:0] cmp_slot(input logic [7:0] off);
    return (off - CLINT_MTIMECMP_BASE) / CLINT_HART_STRIDE;
  endfunction

  function automatic logic cmp_upper(input logic [7:0] off);
    return ((off - CLINT_MTIMECMP_BASE) % CLINT_HART_STRIDE) >= 8'd4;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the system clock down to the mtime tick rate; tick_o is high on the
// cycle the counter wraps from TICK_DIV-1 back to zero.
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// Machine timer / software interrupt slave: mtime, per-hart mtimecmp and msip,
// served through a three-phase req/ready handshake (IDLE, RESP, GAP).
module clint_timer
  import clint_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_be,
  input  logic                 bus_we,
  input  logic                 bus_req,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);

  clint_state_e state_q, state_d;
  logic         accept;
  logic         wrCommit;
  logic [7:0]   reqOff;
  logic         unused_addr_bits;

  logic [7:0]   off_q;
  logic         we_q;
  logic [31:0]  wdata_q;
  logic [3:0]   be_q;
  logic [31:0]  rdata_q;
  logic [31:0]  rdVal;

  logic                       tick;
  logic [63:0]                mtime_q, mtime_d;
  logic [NUM_HARTS-1:0][63:0] cmp_q, cmp_d;
  logic [NUM_HARTS-1:0]       msip_q, msip_d;
  logic [NUM_HARTS-1:0]       tirq_q, tirq_d;
  logic [NUM_HARTS-1:0]       sirq_q;

  // Only the word offset within the 256-byte window is decoded.
  assign reqOff           = {bus_addr[7:2], 2'b00};
  assign unused_addr_bits = ^{bus_addr[31:8], bus_addr[1:0]};

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          accept  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_ready = (state_q == ST_RESP);
  assign bus_rdata = bus_ready ? rdata_q : '0;
  assign wrCommit  = bus_ready && we_q;

  // Read data is captured at accept time, so it reflects the registers then.
  always_comb begin
    rdVal = '0;
    if (reqOff == CLINT_MTIME_LO) begin
      rdVal = mtime_q[31:0];
    end else if (reqOff == CLINT_MTIME_HI) begin
      rdVal = mtime_q[63:32];
    end else if (reqOff == CLINT_MSIP) begin
      rdVal[NUM_HARTS-1:0] = msip_q;
    end else if (is_cmp_off(reqOff)) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (cmp_slot(reqOff) == 8'(h)) begin
          rdVal = cmp_upper(reqOff) ? cmp_q[h][63:32] : cmp_q[h][31:0];
        end
      end
    end
  end

  // Written mtime bytes override the incremented value without any carry.
  always_comb begin
    mtime_d = mtime_q + 64'(tick);
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    if (wrCommit) begin
      if (off_q == CLINT_MTIME_LO) mtime_d[31:0]  = merge_be(mtime_d[31:0], wdata_q, be_q);
      if (off_q == CLINT_MTIME_HI) mtime_d[63:32] = merge_be(mtime_d[63:32], wdata_q, be_q);
      if (off_q == CLINT_MSIP && be_q[0]) msip_d = wdata_q[NUM_HARTS-1:0];
      if (is_cmp_off(off_q)) begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (cmp_slot(off_q) == 8'(h)) begin
            if (cmp_upper(off_q)) cmp_d[h][63:32] = merge_be(cmp_q[h][63:32], wdata_q, be_q);
            else                  cmp_d[h][31:0]  = merge_be(cmp_q[h][31:0], wdata_q, be_q);
          end
        end
      end
    end
  end

  always_comb begin
    tirq_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      tirq_d[h] = (mtime_q >= cmp_q[h]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= reqOff;
        we_q    <= bus_we;
        wdata_q <= bus_wdata;
        be_q    <= bus_be;
        rdata_q <= rdVal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      cmp_q   <= {NUM_HARTS{MTIMECMP_RESET}};
      msip_q  <= '0;
      tirq_q  <= '0;
      sirq_q  <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      tirq_q  <= tirq_d;
      sirq_q  <= msip_q;
    end
  end

  assign timer_irq = tirq_q;
  assign soft_irq  = sirq_q;

endmodule
